instruction_fetch_unit: RTL and testbench

- Front end of the single-cycle core; sits directly upstream of the decode/control stage.
- Holds the fetch PC and issues word requests to instruction memory over a req/gnt/rvalid interface that tolerates variable latency.
- Buffers returned words in a small in-order FIFO.
- Presents {instruction, pc} to decode with a valid/ready handshake, and supports PC redirect (branch/jump) with flush of buffered and in-flight fetches.

---
 rtl/instruction_fetch_unit.sv | 158 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Fetch front end. Issues word fetches over req/gnt/rvalid,
//               buffers responses in order and hands {instr, pc} to decode.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w:0] c_depth = (c_cnt_w + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [31:0]        r_fetch_pc;
    logic [c_cnt_w-1:0] r_outstanding;
    logic [c_cnt_w-1:0] r_discard;
    logic [c_cnt_w-1:0] r_fifo_count;
    logic [c_ptr_w-1:0] r_fifo_rd;
    logic [c_ptr_w-1:0] r_fifo_wr;
    logic [c_ptr_w-1:0] r_pcq_rd;
    logic [c_ptr_w-1:0] r_pcq_wr;
    logic [31:0]        r_pcq        [FIFO_DEPTH];
    logic [31:0]        r_fifo_instr [FIFO_DEPTH];
    logic [31:0]        r_fifo_pc    [FIFO_DEPTH];

    logic               w_resp;
    logic               w_drop;
    logic               w_push;
    logic               w_pop;
    logic               w_grant;
    logic [c_cnt_w:0]   w_occupancy;
    logic [c_ptr_w-1:0] w_next_idx;

    assign w_resp  = imem_rvalid && (r_outstanding != '0);
    assign w_drop  = w_resp && (r_discard != '0);
    assign w_push  = w_resp && !w_drop && !redirect_valid;
    assign w_pop   = instr_valid && instr_ready && !redirect_valid;
    assign w_grant = imem_req && imem_gnt;

    // A same-cycle pop frees a slot, which lets zero-latency memory stream
    // one word per cycle with only two buffer entries.
    assign w_occupancy = {1'b0, r_outstanding} + {1'b0, r_fifo_count}
                       - {{c_cnt_w{1'b0}}, w_pop};

    always_comb begin
        w_state_next = r_state;
        imem_req     = 1'b0;
        case (r_state)
            S_BOOT: w_state_next = S_RUN;
            S_RUN:  imem_req = !redirect_valid && (w_occupancy < c_depth);
        endcase
    end

    // Oldest in-flight request that will actually be delivered.
    assign w_next_idx = r_pcq_rd + r_discard[c_ptr_w-1:0];

    assign imem_addr   = r_fetch_pc;
    assign instr_valid = (r_fifo_count != '0);
    assign instr       = instr_valid ? r_fifo_instr[r_fifo_rd] : NOP_INSTR;
    assign instr_pc    = instr_valid ? r_fifo_pc[r_fifo_rd]
                       : ((r_outstanding > r_discard) ? r_pcq[w_next_idx] : r_fetch_pc);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_BOOT;
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_fifo_count  <= '0;
            r_fifo_rd     <= '0;
            r_fifo_wr     <= '0;
            r_pcq_rd      <= '0;
            r_pcq_wr      <= '0;
        end else begin
            r_state <= w_state_next;

            if (redirect_valid) begin
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            end else if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end

            r_outstanding <= r_outstanding + c_cnt_w'(w_grant) - c_cnt_w'(w_resp);

            // Every request still in flight at a redirect is stale, so the
            // drop count becomes what remains outstanding after this cycle.
            if (redirect_valid) begin
                r_discard <= r_outstanding - c_cnt_w'(w_resp);
            end else if (w_drop) begin
                r_discard <= r_discard - c_cnt_w'(1);
            end

            if (w_grant) begin
                r_pcq_wr <= r_pcq_wr + c_ptr_w'(1);
            end
            if (w_resp) begin
                r_pcq_rd <= r_pcq_rd + c_ptr_w'(1);
            end

            if (redirect_valid) begin
                r_fifo_count <= '0;
                r_fifo_rd    <= '0;
                r_fifo_wr    <= '0;
            end else begin
                if (w_push) begin
                    r_fifo_wr <= r_fifo_wr + c_ptr_w'(1);
                end
                if (w_pop) begin
                    r_fifo_rd <= r_fifo_rd + c_ptr_w'(1);
                end
                r_fifo_count <= r_fifo_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_pcq[r_pcq_wr] <= r_fetch_pc;
        end
        if (w_push) begin
            r_fifo_instr[r_fifo_wr] <= imem_rdata;
            r_fifo_pc[r_fifo_wr]    <= r_pcq[r_pcq_rd];
        end
    end

`ifndef SYNTHESIS
    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!resetn)
        imem_rvalid |-> (r_outstanding != '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Scoreboard bench: granted fetches queue expected words, a
//               monitor checks every word decode accepts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_delivered = 0;
    logic [31:0] last_pc;
    logic [31:0] last_instr;
    logic [31:0] model_pc = RESET_PC;
    bit          gnt_en = 1'b1;
    bit          resp_en = 1'b1;
    logic [31:0] pend[$];
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic        pre_grant, pre_rvalid, pre_redirect;
    logic [31:0] pre_addr;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (2),
        .NOP_INSTR  (NOP_INSTR)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA500_00FF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive memory for this cycle and sample what the coming edge will do.
    task automatic step_pre();
        imem_rvalid = resp_en && (pend.size() != 0);
        imem_rdata  = imem_rvalid ? mem_word(pend[0]) : 32'h0;
        imem_gnt    = gnt_en;
        #1;
        pre_grant    = imem_req && imem_gnt;
        pre_addr     = imem_addr;
        pre_rvalid   = imem_rvalid;
        pre_redirect = redirect_valid;
        if (imem_req) chk("issue_addr", imem_addr, model_pc);
        if (redirect_valid && imem_req) chk("req_during_redirect", 32'(imem_req), 32'h0);
    endtask

    task automatic step_post();
        @(posedge clk);
        if (pre_rvalid) void'(pend.pop_front());
        if (pre_grant) begin
            pend.push_back(pre_addr);
            exp_q.push_back('{instr: mem_word(pre_addr), pc: pre_addr});
            model_pc = pre_addr + 32'd4;
        end
        if (pre_redirect) begin
            exp_q.delete();
            model_pc = {redirect_pc[31:2], 2'b00};
        end
        @(negedge clk);
    endtask

    task automatic step();
        step_pre();
        step_post();
    endtask

    task automatic wait_delivery(input string name, input logic [31:0] exp_pc);
        int base;
        bit got;
        base = n_delivered;
        got  = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            if (n_delivered != base) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: no instruction within 30 cycles, expected pc %h", name, exp_pc);
        end else begin
            chk(name, last_pc, exp_pc);
            chk({name, "_instr"}, last_instr, mem_word(exp_pc));
        end
    endtask

    task automatic wait_req(input string name, input logic [31:0] exp_addr);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step_pre();
            if (imem_req) begin
                chk(name, imem_addr, exp_addr);
                got = 1'b1;
            end
            step_post();
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: no request within 30 cycles, expected addr %h", name, exp_addr);
        end
    endtask

    task automatic do_reset();
        resetn         = 1'b0;
        imem_rvalid    = 1'b0;
        imem_gnt       = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("rst_instr_valid", 32'(instr_valid), 32'h0);
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_instr", instr, NOP_INSTR);
        chk("rst_instr_pc", instr_pc, RESET_PC);
        pend.delete();
        exp_q.delete();
        model_pc = RESET_PC;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Monitor: checks every word decode accepts against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (resetn && !redirect_valid) begin
                if (instr_valid && instr_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_instr: got pc %h, none expected", instr_pc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("sb_instr", instr, mon_e.instr);
                        chk("sb_instr_pc", instr_pc, mon_e.pc);
                    end
                    n_delivered++;
                    last_pc    = instr_pc;
                    last_instr = instr;
                end else if (!instr_valid) begin
                    chk("idle_nop", instr, NOP_INSTR);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        @(negedge clk);
        do_reset();

        // Boot cycle, then first fetch at RESET_PC; valid after the 3rd edge.
        step_pre();
        chk("boot_req", 32'(imem_req), 32'h0);
        step_post();
        step_pre();
        chk("first_req", 32'(imem_req), 32'h1);
        chk("first_addr", imem_addr, 32'h0000_0000);
        step_post();
        chk("valid_after_2", 32'(instr_valid), 32'h0);
        step();
        chk("valid_after_3", 32'(instr_valid), 32'h1);
        chk("first_pc", instr_pc, 32'h0000_0000);
        chk("first_instr", instr, mem_word(32'h0));
        base = n_delivered;
        repeat (6) step();
        chk("throughput", 32'(n_delivered - base), 32'd6);

        // Mid-stream reset, then back-pressure fills the buffer with 0x0, 0x4.
        do_reset();
        instr_ready = 1'b0;
        repeat (6) step();
        step_pre();
        chk("full_req", 32'(imem_req), 32'h0);
        chk("full_valid", 32'(instr_valid), 32'h1);
        chk("full_head_pc", instr_pc, 32'h0000_0000);
        chk("full_grants", 32'(exp_q.size()), 32'd2);
        step_post();

        // Drain with grant stalled: address holds at 0x8.
        instr_ready = 1'b1;
        gnt_en      = 1'b0;
        base        = n_delivered;
        for (int i = 0; i < 3; i++) begin
            step_pre();
            chk("stall_req", 32'(imem_req), 32'h1);
            chk("stall_addr", imem_addr, 32'h0000_0008);
            step_post();
        end
        chk("drain_count", 32'(n_delivered - base), 32'd2);
        chk("drain_last_pc", last_pc, 32'h0000_0004);

        // Two requests in flight (0x8, 0xC), then redirect to 0x101.
        gnt_en = 1'b1;
        step();
        resp_en = 1'b0;
        step();
        chk("inflight", 32'(pend.size()), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0101;
        step_pre();
        chk("redirect_req", 32'(imem_req), 32'h0);
        step_post();
        redirect_valid = 1'b0;
        resp_en        = 1'b1;
        wait_req("redir_addr", 32'h0000_0100);
        wait_delivery("redir_pc", 32'h0000_0100);

        // Redirect coincident with a response and a pop.
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step_pre();
        chk("coinc_valid", 32'(instr_valid), 32'h1);
        step_post();
        redirect_valid = 1'b0;
        wait_delivery("coinc_pc", 32'h0000_0200);

        // Back-to-back redirects with two stale requests outstanding.
        repeat (2) step();
        resp_en = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        step();
        redirect_pc = 32'h0000_0404;
        resp_en     = 1'b1;
        step();
        redirect_valid = 1'b0;
        wait_delivery("b2b_pc", 32'h0000_0404);

        // Address wrap at the top of the space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        step();
        redirect_valid = 1'b0;
        wait_delivery("wrap_top", 32'hFFFF_FFFC);
        wait_delivery("wrap_zero", 32'h0000_0000);

        // Reset mid-stream restarts at RESET_PC.
        do_reset();
        wait_delivery("restart_pc", RESET_PC);

        // Redirect during the boot cycle is taken.
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0045;
        step_pre();
        chk("boot_redirect_req", 32'(imem_req), 32'h0);
        step_post();
        redirect_valid = 1'b0;
        wait_delivery("boot_redirect_pc", 32'h0000_0044);

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
